atm: RTL and testbench
======================

ATM -- requirements
Module: atm

Interface
REQ-001 SHALL have exactly one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 Ports, in order (name  direction  width  meaning):
  clk  in  1  clock, all state updates on rising edge
  rst_n  in  1  async active-low reset
  exit  in  1  end session, sampled on clk
  accNumber  in  12  account number of the card holder
  pin  in  4  PIN entered
  destinationAccNumber  in  12  target account for TRANSACTION
  menuOption  in  3  requested operation
  amount  in  11  withdraw/transfer amount, unsigned
  depAmount  in  32  deposit amount, signed integer
  error  out  1  registered, 1 = last operation rejected
  balance  out  11  registered, displayed balance
REQ-003 menuOption codes SHALL be: 3 BALANCE, 4 WITHDRAW, 5 WITHDRAW_SHOW_BALANCE, 6 TRANSACTION, 7 DEPOSIT; 0/1/2 are no-ops.

Function
REQ-004 SHALL hold a fixed 10-entry account table (number/PIN): 2749/0, 2175/1, 2429/2, 2125/3, 2178/4, 2647/5, 2816/6, 2910/7, 2299/8, 2689/9; each entry has an 11-bit balance register.
REQ-005 Each rising clk edge SHALL be one transaction; exit=1 has priority: clears session, error<=0, balance<=0, no table change.
REQ-006 With exit=0: lookup of accNumber; if not found or pin mismatch -> error<=1, balance unchanged, no table change (state WAITING/GET_PIN failure).
REQ-007 With valid credentials the session SHALL be active and the menuOption executed in that same edge (states MENU -> op -> MENU); error<=0 unless the op fails.
REQ-008 BALANCE: balance<=account balance.
REQ-009 WITHDRAW: if amount <= balance, subtract; else error<=1, no change; balance output unchanged.
REQ-010 WITHDRAW_SHOW_BALANCE: as WITHDRAW; on success balance<=new balance.
REQ-011 TRANSACTION: error<=1, no change, if destination not in table, equals source, amount > source balance, or destination balance + amount > 2047 (compare in 12 bits); else debit source, credit destination; balance output unchanged.
REQ-012 DEPOSIT: error<=1, no change, if depAmount < 0, depAmount > 2047, or balance + depAmount > 2047; else add, balance<=new balance.
REQ-013 Arithmetic SHALL never wrap; every overflow/underflow is an error with the table untouched.
REQ-014 No-op codes SHALL leave the table and balance output unchanged, error<=0.
REQ-015 amount is 11 bits; wider values are truncated by the driver (2500 arrives as 452).

Reset
REQ-016 rst_n=0 SHALL immediately set every account balance to 500, error=0, balance=0, session cleared; reset mid-session discards it.
REQ-017 After rst_n deasserts, the first rising edge SHALL be processed normally.

Configuration
REQ-018 Macro ATM_DEPOSIT_EN: defined -> DEPOSIT per REQ-012; undefined -> menuOption 7 sets error<=1, no balance change, and depAmount is ignored.

Verification
REQ-019 After reset: accNumber 2278, pin 4, BALANCE -> error=1, balance=0.
REQ-020 2178/4: WITHDRAW_SHOW_BALANCE amount 100 -> balance=400, error=0; then WITHDRAW amount 452 -> error=1; BALANCE -> 400.
REQ-021 2178/4: TRANSACTION amount 50 to 2816 -> error=0, source 350; TRANSACTION amount 502 -> error=1, balances unchanged.
REQ-022 2178/4 (350): DEPOSIT 500 -> balance=850; DEPOSIT 2550 -> error=1; DEPOSIT 65535 -> error=1; balance stays 850.
REQ-023 exit=1 edge -> balance=0, error=0; then 2816/6 BALANCE -> 550.
REQ-024 rst_n pulsed low mid-session -> outputs 0 asynchronously; 2816/6 BALANCE -> 500.

Source files
------------

// File: rtl/atm.sv
// atm: ten-account teller, one transaction per rising clock edge.
// Defining ATM_DEPOSIT_EN enables the DEPOSIT operation (menuOption 7).
module atm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exit,
  input  logic [11:0] accNumber,
  input  logic [3:0]  pin,
  input  logic [11:0] destinationAccNumber,
  input  logic [2:0]  menuOption,
  input  logic [10:0] amount,
  input  logic [31:0] depAmount,
  output logic        error,
  output logic [10:0] balance
);

  localparam int NACC = 10;
  localparam logic [11:0] ACC_NUM [NACC] = '{
    12'd2749, 12'd2175, 12'd2429, 12'd2125, 12'd2178,
    12'd2647, 12'd2816, 12'd2910, 12'd2299, 12'd2689
  };
  localparam logic [10:0] BAL_INIT = 11'd500;

  localparam logic [2:0] OP_BAL = 3'd3;
  localparam logic [2:0] OP_WD  = 3'd4;
  localparam logic [2:0] OP_WDS = 3'd5;
  localparam logic [2:0] OP_TX  = 3'd6;
  localparam logic [2:0] OP_DEP = 3'd7;

  logic [10:0]     bal_q [NACC];
  logic [10:0]     bal_d [NACC];
  logic            error_q, error_d;
  logic [10:0]     balance_q, balance_d;

  logic [NACC-1:0] src_sel, dst_sel;
  logic            pin_ok;
  logic [10:0]     src_bal, dst_bal;
  logic [10:0]     src_left;
  logic [11:0]     dst_sum;

  // PIN of table entry i is simply i.
  always_comb begin
    src_sel = '0;
    dst_sel = '0;
    pin_ok  = 1'b0;
    src_bal = '0;
    dst_bal = '0;
    for (int i = 0; i < NACC; i++) begin
      if (accNumber == ACC_NUM[i]) begin
        src_sel[i] = 1'b1;
        src_bal    = bal_q[i];
        pin_ok     = (pin == 4'(i));
      end
      if (destinationAccNumber == ACC_NUM[i]) begin
        dst_sel[i] = 1'b1;
        dst_bal    = bal_q[i];
      end
    end
  end

  assign src_left = src_bal - amount;
  assign dst_sum  = {1'b0, dst_bal} + {1'b0, amount};

`ifdef ATM_DEPOSIT_EN
  logic [11:0] dep_sum;
  logic        dep_bad;
  assign dep_sum = {1'b0, src_bal} + {1'b0, depAmount[10:0]};
  assign dep_bad = depAmount[31] | (|depAmount[30:11]) | dep_sum[11];
`else
  logic dep_unused;
  assign dep_unused = ^depAmount;
`endif

  always_comb begin
    bal_d     = bal_q;
    error_d   = 1'b0;
    balance_d = balance_q;
    if (exit) begin
      balance_d = '0;
    end else if (!pin_ok) begin
      error_d = 1'b1;
    end else begin
      case (menuOption)
        OP_BAL: balance_d = src_bal;
        OP_WD, OP_WDS: begin
          if (amount > src_bal) begin
            error_d = 1'b1;
          end else begin
            for (int i = 0; i < NACC; i++)
              if (src_sel[i]) bal_d[i] = src_left;
            if (menuOption == OP_WDS) balance_d = src_left;
          end
        end
        OP_TX: begin
          if (dst_sel == '0 || dst_sel == src_sel ||
              amount > src_bal || dst_sum[11]) begin
            error_d = 1'b1;
          end else begin
            for (int i = 0; i < NACC; i++) begin
              if (src_sel[i]) bal_d[i] = src_left;
              if (dst_sel[i]) bal_d[i] = dst_sum[10:0];
            end
          end
        end
        OP_DEP: begin
`ifdef ATM_DEPOSIT_EN
          if (dep_bad) begin
            error_d = 1'b1;
          end else begin
            for (int i = 0; i < NACC; i++)
              if (src_sel[i]) bal_d[i] = dep_sum[10:0];
            balance_d = dep_sum[10:0];
          end
`else
          error_d = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NACC; i++) bal_q[i] <= BAL_INIT;
      error_q   <= 1'b0;
      balance_q <= '0;
    end else begin
      bal_q     <= bal_d;
      error_q   <= error_d;
      balance_q <= balance_d;
    end
  end

  assign error   = error_q;
  assign balance = balance_q;

endmodule

// File: tb/tb_atm.sv
// tb_atm: directed vector table plus randomized run against a
// behavioural account model; honours ATM_DEPOSIT_EN like the design.
module tb_atm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exit = 1'b0;
  logic [11:0] accNumber = '0;
  logic [3:0]  pin = '0;
  logic [11:0] destinationAccNumber = '0;
  logic [2:0]  menuOption = '0;
  logic [10:0] amount = '0;
  logic [31:0] depAmount = '0;
  logic        error;
  logic [10:0] balance;

  atm dut (
    .clk(clk), .rst_n(rst_n), .exit(exit),
    .accNumber(accNumber), .pin(pin),
    .destinationAccNumber(destinationAccNumber),
    .menuOption(menuOption), .amount(amount),
    .depAmount(depAmount), .error(error), .balance(balance)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ex;
    logic [11:0] acc;
    logic [3:0]  pn;
    logic [11:0] dst;
    logic [2:0]  op;
    logic [10:0] amt;
    logic [31:0] dep;
    logic        e_err;
    logic [10:0] e_bal;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  int accs [10] = '{2749, 2175, 2429, 2125, 2178,
                    2647, 2816, 2910, 2299, 2689};
  int pins [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int m_bal [10];
  int m_out;
  int m_err;

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(vec_t v);
    exit = v.ex;
    accNumber = v.acc;
    pin = v.pn;
    destinationAccNumber = v.dst;
    menuOption = v.op;
    amount = v.amt;
    depAmount = v.dep;
    @(posedge clk);
    #1;
  endtask

  function automatic int find(int a);
    for (int i = 0; i < 10; i++)
      if (accs[i] == a) return i;
    return -1;
  endfunction

  // Reference: one transaction applied to integer balances.
  task automatic model_step(vec_t v);
    int s, d, amt, dep;
    amt = int'(v.amt);
    dep = int'($signed(v.dep));
    m_err = 0;
    if (v.ex) begin
      m_out = 0;
      return;
    end
    s = find(int'(v.acc));
    if (s < 0 || pins[s] != int'(v.pn)) begin
      m_err = 1;
      return;
    end
    case (int'(v.op))
      3: m_out = m_bal[s];
      4, 5: begin
        if (amt > m_bal[s]) m_err = 1;
        else begin
          m_bal[s] -= amt;
          if (v.op == 3'd5) m_out = m_bal[s];
        end
      end
      6: begin
        d = find(int'(v.dst));
        if (d < 0 || d == s || amt > m_bal[s] || m_bal[d] + amt > 2047)
          m_err = 1;
        else begin
          m_bal[s] -= amt;
          m_bal[d] += amt;
        end
      end
      7: begin
`ifdef ATM_DEPOSIT_EN
        if (dep < 0 || dep > 2047 || m_bal[s] + dep > 2047) m_err = 1;
        else begin
          m_bal[s] += dep;
          m_out = m_bal[s];
        end
`else
        m_err = 1;
`endif
      end
      default: ;
    endcase
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    //        ex  acc    pin dst   op amt  dep    err bal
    vecs.push_back('{0, 2278, 4, 0,    3, 0,   0,     1, 0});
    vecs.push_back('{0, 2178, 4, 0,    5, 100, 0,     0, 400});
    vecs.push_back('{0, 2178, 4, 0,    4, 452, 0,     1, 400});
    vecs.push_back('{0, 2178, 4, 0,    3, 0,   0,     0, 400});
    vecs.push_back('{0, 2178, 4, 2816, 6, 50,  0,     0, 400});
    vecs.push_back('{0, 2178, 4, 0,    3, 0,   0,     0, 350});
    vecs.push_back('{0, 2178, 4, 2816, 6, 502, 0,     1, 350});
    vecs.push_back('{0, 2178, 4, 2178, 6, 10,  0,     1, 350});
    vecs.push_back('{0, 2178, 4, 1234, 6, 10,  0,     1, 350});
`ifdef ATM_DEPOSIT_EN
    vecs.push_back('{0, 2178, 4, 0,    7, 0,   500,   0, 850});
    vecs.push_back('{0, 2178, 4, 0,    7, 0,   2550,  1, 850});
    vecs.push_back('{0, 2178, 4, 0,    7, 0,   65535, 1, 850});
    vecs.push_back('{0, 2178, 4, 0,    7, 0,   -5,    1, 850});
    vecs.push_back('{0, 2178, 4, 0,    3, 0,   0,     0, 850});
`else
    vecs.push_back('{0, 2178, 4, 0,    7, 0,   500,   1, 350});
    vecs.push_back('{0, 2178, 4, 0,    3, 0,   0,     0, 350});
`endif
    vecs.push_back('{1, 2178, 4, 0,    3, 0,   0,     0, 0});
    vecs.push_back('{0, 2816, 6, 0,    3, 0,   0,     0, 550});
    vecs.push_back('{0, 2816, 5, 0,    3, 0,   0,     1, 550});
    vecs.push_back('{0, 2816, 6, 0,    1, 0,   0,     0, 550});
    vecs.push_back('{0, 2125, 3, 0,    5, 500, 0,     0, 0});
    vecs.push_back('{0, 2125, 3, 0,    4, 1,   0,     1, 0});
    vecs.push_back('{0, 2125, 3, 0,    3, 0,   0,     0, 0});
    vecs.push_back('{0, 2816, 6, 0,    3, 0,   0,     0, 550});

    #12;
    check("reset_err", int'(error), 0);
    check("reset_bal", int'(balance), 0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k]);
      check($sformatf("vec%0d_err", k), int'(error), int'(vecs[k].e_err));
      check($sformatf("vec%0d_bal", k), int'(balance), int'(vecs[k].e_bal));
    end

    // Asynchronous reset in the middle of a session.
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_bal", int'(balance), 0);
    check("async_rst_err", int'(error), 0);
    #1 rst_n = 1'b1;
    drive('{0, 2816, 6, 0, 3, 0, 0, 0, 0});
    check("post_rst_2816", int'(balance), 500);
    drive('{0, 2178, 4, 0, 3, 0, 0, 0, 0});
    check("post_rst_2178", int'(balance), 500);

    for (int i = 0; i < 10; i++) m_bal[i] = 500;
    m_out = 500;
    m_err = 0;

    for (int n = 0; n < 400; n++) begin
      int idx;
      idx = $urandom_range(0, 9);
      v.ex  = ($urandom_range(0, 19) == 0);
      v.acc = ($urandom_range(0, 9) < 9) ? 12'(accs[idx]) : 12'($urandom);
      v.pn  = ($urandom_range(0, 4) < 4) ? 4'(idx) : 4'($urandom);
      v.dst = ($urandom_range(0, 9) < 8) ?
              12'(accs[$urandom_range(0, 9)]) : 12'($urandom);
      v.op  = 3'($urandom_range(0, 7));
      v.amt = ($urandom_range(0, 1) == 1) ?
              11'($urandom_range(0, 300)) : 11'($urandom);
      case ($urandom_range(0, 3))
        0: v.dep = 32'($urandom_range(0, 600));
        1: v.dep = -32'($urandom_range(1, 100));
        2: v.dep = 32'($urandom_range(1500, 3000));
        default: v.dep = $urandom;
      endcase
      v.e_err = 1'b0;
      v.e_bal = '0;
      model_step(v);
      drive(v);
      check($sformatf("rnd%0d_err", n), int'(error), m_err);
      check($sformatf("rnd%0d_bal", n), int'(balance), m_out);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
